hwpe_stream_fifo_earlystall_param: RTL and testbench

Parametrised successor of the HWPE stream early-stall FIFO: a single-clock, first-word-fall-through FIFO between an HWPE stream producer and consumer. It is generalised in data width, depth and stall margin. push_ready_o is a function of registered occupancy only, so there is no combinational path from pop_ready_i to push_ready_o. A local flush (clear_i) is synchronous and kept strictly separate from the global asynchronous reset.

---
 rtl/hwpe_stream_fifo_pkg.sv | 20 ++
 rtl/hwpe_stream_fifo_mem.sv | 24 ++
 rtl/hwpe_stream_fifo_earlystall_param.sv | 114 +++++++++++
 tb/tb_hwpe_stream_fifo_earlystall_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_stream_fifo_pkg.sv
// Shared types and sizing helpers for the HWPE stream early-stall FIFO family.
package hwpe_stream_fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        MIDDLE = 2'd1,
        FULL   = 2'd2
    } fifo_state_e;

    // Highest occupancy reachable once the early-stall entries are held back.
    function automatic int unsigned usable_f(input int unsigned depth, input int unsigned margin);
        return depth - margin;
    endfunction

    // The occupancy counter must be able to hold the value FIFO_DEPTH itself.
    function automatic int unsigned cnt_width_f(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hwpe_stream_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module hwpe_stream_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hwpe_stream_fifo_earlystall_param.sv
// First-word-fall-through stream FIFO whose push_ready depends only on registered
// occupancy, with a configurable number of entries held back for early stall.
module hwpe_stream_fifo_earlystall_param
    import hwpe_stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned STALL_MARGIN = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        push_valid_i,
    input  logic [DATA_WIDTH-1:0]       push_data_i,
    output logic                        push_ready_o,
    output logic                        pop_valid_o,
    output logic [DATA_WIDTH-1:0]       pop_data_o,
    input  logic                        pop_ready_i,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        empty_o,
    output logic                        full_o
);

    localparam int unsigned USABLE = usable_f(FIFO_DEPTH, STALL_MARGIN);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = cnt_width_f(FIFO_DEPTH);

    fifo_state_e        state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   push_ptr_q, push_ptr_d;
    logic [PTR_W-1:0]   pop_ptr_q, pop_ptr_d;
    logic               push;
    logic               pop;

    // Handshake flags decode the state register only; no path from pop_ready_i.
    assign push_ready_o = (state_q != FULL);
    assign pop_valid_o  = (state_q != EMPTY);
    assign empty_o      = (state_q == EMPTY);
    assign full_o       = (state_q == FULL);
    assign count_o      = count_q;

    assign push = push_valid_i & push_ready_o;
    assign pop  = pop_valid_o & pop_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= EMPTY;
            count_q    <= '0;
            push_ptr_q <= '0;
            pop_ptr_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            push_ptr_q <= push_ptr_d;
            pop_ptr_q  <= pop_ptr_d;
        end
    end

    // Next occupancy and pointers; clear drops any same-cycle push or pop.
    always_comb begin
        count_d    = count_q;
        push_ptr_d = push_ptr_q;
        pop_ptr_d  = pop_ptr_q;
        state_d    = state_q;

        if (clear_i) begin
            count_d    = '0;
            push_ptr_d = '0;
            pop_ptr_d  = '0;
        end else begin
            if (push) begin
                push_ptr_d = push_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                pop_ptr_d = pop_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        if (count_d == '0) begin
            state_d = EMPTY;
        end else if (count_d == CNT_W'(USABLE)) begin
            state_d = FULL;
        end else begin
            state_d = MIDDLE;
        end
    end

    hwpe_stream_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) i_mem (
        .clk   (clk_i),
        .we    (push & ~clear_i),
        .waddr (push_ptr_q),
        .wdata (push_data_i),
        .raddr (pop_ptr_q),
        .rdata (pop_data_o)
    );

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CNT_W'(USABLE));

    a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (pop_valid_o && !pop_ready_i && !clear_i) |=> $stable(pop_data_o));

    a_no_push_when_stalled: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (!push_ready_o && !clear_i) |=> (count_q <= $past(count_q)));

endmodule

// File: tb/tb_hwpe_stream_fifo_earlystall_param.sv
// Directed bench for the early-stall FIFO with a queue scoreboard and negedge monitor.
module tb_hwpe_stream_fifo_earlystall_param;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned USE   = 7;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          push_valid_i;
    logic [DW-1:0] push_data_i;
    logic          push_ready_o;
    logic          pop_valid_o;
    logic [DW-1:0] pop_data_o;
    logic          pop_ready_i;
    logic [3:0]    count_o;
    logic          empty_o;
    logic          full_o;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb[$];
    bit            seen_dead = 1'b0;

    always #5 clk_i = ~clk_i;

    hwpe_stream_fifo_earlystall_param #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .STALL_MARGIN (1)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .push_valid_i (push_valid_i),
        .push_data_i  (push_data_i),
        .push_ready_o (push_ready_o),
        .pop_valid_o  (pop_valid_o),
        .pop_data_o   (pop_data_o),
        .pop_ready_i  (pop_ready_i),
        .count_o      (count_o),
        .empty_o      (empty_o),
        .full_o       (full_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_n(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push_valid_i = 1'b1;
            push_data_i  = base + DW'(i);
            tick();
        end
        push_valid_i = 1'b0;
    endtask

    task automatic pop_n(input int n);
        pop_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
        end
        pop_ready_i = 1'b0;
    endtask

    // Model occupancy is compared before this cycle's handshakes update the queue.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            sb.delete();
        end else begin
            check("count_vs_model", 32'(count_o), 32'(sb.size()));
            check("empty_vs_model", 32'(empty_o), 32'(sb.size() == 0));
            check("full_vs_model", 32'(full_o), 32'(sb.size() == USE));
            if (pop_valid_o && pop_data_o == 32'h0000_DEAD) begin
                seen_dead = 1'b1;
            end
            if (clear_i) begin
                sb.delete();
            end else begin
                if (pop_valid_o && pop_ready_i) begin
                    if (sb.size() == 0) begin
                        check("pop_on_empty_model", 32'(pop_valid_o), 32'h0);
                    end else begin
                        check("pop_data", pop_data_o, sb.pop_front());
                    end
                end
                if (push_valid_i && push_ready_o) begin
                    sb.push_back(push_data_i);
                end
            end
        end
    end

    initial begin
        rst_ni       = 1'b0;
        clear_i      = 1'b0;
        push_valid_i = 1'b0;
        push_data_i  = '0;
        pop_ready_i  = 1'b0;
        #12;
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_push_ready", 32'(push_ready_o), 32'd1);
        check("rst_pop_valid", 32'(pop_valid_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Fill to the usable limit; an extra beat must be held off.
        push_n(32'h1, 7);
        check("fill_count", 32'(count_o), 32'd7);
        check("fill_full", 32'(full_o), 32'd1);
        check("fill_push_ready", 32'(push_ready_o), 32'd0);
        push_valid_i = 1'b1;
        push_data_i  = 32'h8;
        tick();
        tick();
        push_valid_i = 1'b0;
        check("held_count", 32'(count_o), 32'd7);
        check("held_push_ready", 32'(push_ready_o), 32'd0);

        // Drain: ready must return after the first pop.
        pop_ready_i = 1'b1;
        tick();
        check("drain_push_ready", 32'(push_ready_o), 32'd1);
        check("drain_count", 32'(count_o), 32'd6);
        pop_n(6);
        check("drain_empty", 32'(empty_o), 32'd1);

        // Continuous streaming across pointer wraps.
        pop_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_valid_i = 1'b1;
            push_data_i  = 32'h100 + DW'(i);
            tick();
            check("stream_count", 32'(count_o), 32'd1);
        end
        push_valid_i = 1'b0;
        tick();
        pop_ready_i = 1'b0;
        check("stream_drained", 32'(count_o), 32'd0);

        // Clear overrides a simultaneous push and pop.
        push_n(32'h200, 4);
        check("pre_clear_count", 32'(count_o), 32'd4);
        clear_i      = 1'b1;
        push_valid_i = 1'b1;
        push_data_i  = 32'h0000_DEAD;
        pop_ready_i  = 1'b1;
        tick();
        clear_i      = 1'b0;
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b0;
        check("clear_count", 32'(count_o), 32'd0);
        check("clear_empty", 32'(empty_o), 32'd1);
        push_n(32'h300, 2);
        check("post_clear_head", pop_data_o, 32'h300);
        pop_n(2);
        check("dead_never_seen", 32'(seen_dead), 32'd0);

        // Simultaneous push and pop in the middle state.
        push_n(32'h400, 6);
        push_valid_i = 1'b1;
        push_data_i  = 32'h55;
        pop_ready_i  = 1'b1;
        tick();
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b0;
        check("pushpop_count", 32'(count_o), 32'd6);
        check("pushpop_head", pop_data_o, 32'h401);
        pop_n(6);
        check("pushpop_empty", 32'(empty_o), 32'd1);

        // Asynchronous reset mid-stream.
        push_n(32'h500, 5);
        check("pre_rst_count", 32'(count_o), 32'd5);
        rst_ni = 1'b0;
        #1;
        check("async_rst_count", 32'(count_o), 32'd0);
        check("async_rst_empty", 32'(empty_o), 32'd1);
        check("async_rst_pop_valid", 32'(pop_valid_o), 32'd0);
        check("async_rst_push_ready", 32'(push_ready_o), 32'd1);
        tick();
        rst_ni = 1'b1;
        tick();
        push_n(32'hA5A5_A5A5, 1);
        check("post_rst_valid", 32'(pop_valid_o), 32'd1);
        check("post_rst_data", pop_data_o, 32'hA5A5_A5A5);
        pop_n(1);
        check("final_empty", 32'(empty_o), 32'd1);
        tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
